// File: rtl/csr_commit_sequencer_pkg.sv
// Shared constants for the CSR commit sequencer: CSR numbers, exception codes,
// write masks and the FSM state encoding.
// Optional feature macro: CSR_SEQ_BADV_EN adds the BADV write state for ADE/ALE.
package csr_seq_pkg;

  localparam int CSR_NUM_W = 14;
  localparam int DATA_W    = 32;

  localparam logic [CSR_NUM_W-1:0] CSR_CRMD   = 14'h000;
  localparam logic [CSR_NUM_W-1:0] CSR_PRMD   = 14'h001;
  localparam logic [CSR_NUM_W-1:0] CSR_ESTAT  = 14'h005;
  localparam logic [CSR_NUM_W-1:0] CSR_ERA    = 14'h006;
  localparam logic [CSR_NUM_W-1:0] CSR_BADV   = 14'h007;
  localparam logic [CSR_NUM_W-1:0] CSR_EENTRY = 14'h00c;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;

  localparam logic [DATA_W-1:0] PLV_IE_MASK = 32'h0000_0007;
  localparam logic [DATA_W-1:0] ESTAT_WMASK = 32'h7FFF_0000;
  localparam logic [DATA_W-1:0] FULL_MASK   = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_EX_RD_CRMD   = 4'd1,
    ST_EX_WR_PRMD   = 4'd2,
    ST_EX_WR_CRMD   = 4'd3,
    ST_EX_WR_ERA    = 4'd4,
    ST_EX_WR_ESTAT  = 4'd5,
`ifdef CSR_SEQ_BADV_EN
    ST_EX_WR_BADV   = 4'd6,
`endif
    ST_EX_RD_EENTRY = 4'd7,
    ST_ER_RD_PRMD   = 4'd8,
    ST_ER_WR_CRMD   = 4'd9,
    ST_ER_RD_ERA    = 4'd10
  } seq_state_e;

  // ESTAT image with EsubCode in [30:22] and Ecode in [21:16]
  function automatic logic [DATA_W-1:0] estat_value(input logic [8:0] esub, input logic [5:0] ecode);
    return {1'b0, esub, ecode, 16'h0000};
  endfunction

endpackage

// File: rtl/csr_commit_sequencer_if.sv
// Bundle of the WB-stage, commit, redirect and CSR-port signals around the
// sequencer. slave = the sequencer, master = the surrounding pipeline/CSR file.
interface csr_commit_sequencer_if;
  import csr_seq_pkg::*;

  logic                 inst_req;
  logic                 inst_we;
  logic [CSR_NUM_W-1:0] inst_num;
  logic [DATA_W-1:0]    inst_wmask;
  logic [DATA_W-1:0]    inst_wdata;
  logic                 inst_ack;
  logic [DATA_W-1:0]    inst_rdata;

  logic                 ex_req;
  logic [5:0]           ex_ecode;
  logic [8:0]           ex_esubcode;
  logic [DATA_W-1:0]    ex_pc;
  logic [DATA_W-1:0]    ex_vaddr;
  logic                 ertn_req;

  logic                 busy;
  logic                 redir_valid;
  logic [DATA_W-1:0]    redir_pc;

  logic [CSR_NUM_W-1:0] csr_num;
  logic                 csr_we;
  logic [DATA_W-1:0]    csr_wmask;
  logic [DATA_W-1:0]    csr_wvalue;
  logic [DATA_W-1:0]    csr_rvalue;

  modport slave (
    input  inst_req, inst_we, inst_num, inst_wmask, inst_wdata,
    input  ex_req, ex_ecode, ex_esubcode, ex_pc, ex_vaddr, ertn_req,
    input  csr_rvalue,
    output inst_ack, inst_rdata, busy, redir_valid, redir_pc,
    output csr_num, csr_we, csr_wmask, csr_wvalue
  );

  modport master (
    output inst_req, inst_we, inst_num, inst_wmask, inst_wdata,
    output ex_req, ex_ecode, ex_esubcode, ex_pc, ex_vaddr, ertn_req,
    output csr_rvalue,
    input  inst_ack, inst_rdata, busy, redir_valid, redir_pc,
    input  csr_num, csr_we, csr_wmask, csr_wvalue
  );

endinterface

// File: rtl/csr_commit_sequencer.sv
// Owner of the single CSR-file port. Arbitrates exception commit > ertn commit >
// WB CSR instructions, walks the multi-register exception/ertn updates one CSR
// access per cycle, and raises a one-cycle redirect on the final read.
// Optional feature macro: CSR_SEQ_BADV_EN (BADV write for ADE/ALE exceptions).
module csr_commit_sequencer
  import csr_seq_pkg::*;
(
  input logic               clk,
  input logic               resetn,
  csr_commit_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [5:0]        ecode_q, ecode_d;
  logic [8:0]        esub_q, esub_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [2:0]        plv_ie_q, plv_ie_d;
`ifdef CSR_SEQ_BADV_EN
  logic [DATA_W-1:0] vaddr_q, vaddr_d;
`endif
  logic              inst_sel;

  // An instruction access only wins the port when idle and no commit arrives
  assign inst_sel = (state_q == ST_IDLE) && !bus.ex_req && !bus.ertn_req && bus.inst_req;
  assign bus.busy = (state_q != ST_IDLE);

  // Next-state selection and capture of exception/ertn context
  always_comb begin
    state_d  = state_q;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    pc_d     = pc_q;
    plv_ie_d = plv_ie_q;
`ifdef CSR_SEQ_BADV_EN
    vaddr_d  = vaddr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.ex_req) begin
          state_d = ST_EX_RD_CRMD;
          ecode_d = bus.ex_ecode;
          esub_d  = bus.ex_esubcode;
          pc_d    = bus.ex_pc;
`ifdef CSR_SEQ_BADV_EN
          vaddr_d = bus.ex_vaddr;
`endif
        end else if (bus.ertn_req) begin
          state_d = ST_ER_RD_PRMD;
        end
      end
      ST_EX_RD_CRMD: begin
        plv_ie_d = bus.csr_rvalue[2:0];
        state_d  = ST_EX_WR_PRMD;
      end
      ST_EX_WR_PRMD:  state_d = ST_EX_WR_CRMD;
      ST_EX_WR_CRMD:  state_d = ST_EX_WR_ERA;
      ST_EX_WR_ERA:   state_d = ST_EX_WR_ESTAT;
`ifdef CSR_SEQ_BADV_EN
      ST_EX_WR_ESTAT: state_d = (ecode_q == ECODE_ADE || ecode_q == ECODE_ALE) ? ST_EX_WR_BADV
                                                                                : ST_EX_RD_EENTRY;
      ST_EX_WR_BADV:  state_d = ST_EX_RD_EENTRY;
`else
      ST_EX_WR_ESTAT: state_d = ST_EX_RD_EENTRY;
`endif
      ST_EX_RD_EENTRY: state_d = ST_IDLE;
      ST_ER_RD_PRMD: begin
        plv_ie_d = bus.csr_rvalue[2:0];
        state_d  = ST_ER_WR_CRMD;
      end
      ST_ER_WR_CRMD:  state_d = ST_ER_RD_ERA;
      ST_ER_RD_ERA:   state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // State and context registers; reset abandons any sequence in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ecode_q  <= '0;
      esub_q   <= '0;
      pc_q     <= '0;
      plv_ie_q <= '0;
`ifdef CSR_SEQ_BADV_EN
      vaddr_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      pc_q     <= pc_d;
      plv_ie_q <= plv_ie_d;
`ifdef CSR_SEQ_BADV_EN
      vaddr_q  <= vaddr_d;
`endif
    end
  end

  // CSR port mux, instruction response and redirect strobe
  always_comb begin
    bus.csr_num     = '0;
    bus.csr_we      = 1'b0;
    bus.csr_wmask   = '0;
    bus.csr_wvalue  = '0;
    bus.inst_ack    = inst_sel;
    bus.inst_rdata  = inst_sel ? bus.csr_rvalue : '0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = '0;
    case (state_q)
      ST_IDLE: begin
        if (inst_sel) begin
          bus.csr_num    = bus.inst_num;
          bus.csr_we     = bus.inst_we;
          bus.csr_wmask  = bus.inst_wmask;
          bus.csr_wvalue = bus.inst_wdata;
        end
      end
      ST_EX_RD_CRMD: bus.csr_num = CSR_CRMD;
      ST_EX_WR_PRMD: begin
        bus.csr_num    = CSR_PRMD;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = PLV_IE_MASK;
        bus.csr_wvalue = {29'b0, plv_ie_q};
      end
      ST_EX_WR_CRMD: begin
        bus.csr_num    = CSR_CRMD;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = PLV_IE_MASK;
      end
      ST_EX_WR_ERA: begin
        bus.csr_num    = CSR_ERA;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = FULL_MASK;
        bus.csr_wvalue = pc_q;
      end
      ST_EX_WR_ESTAT: begin
        bus.csr_num    = CSR_ESTAT;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = ESTAT_WMASK;
        bus.csr_wvalue = estat_value(esub_q, ecode_q);
      end
`ifdef CSR_SEQ_BADV_EN
      ST_EX_WR_BADV: begin
        bus.csr_num    = CSR_BADV;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = FULL_MASK;
        bus.csr_wvalue = vaddr_q;
      end
`endif
      ST_EX_RD_EENTRY: begin
        bus.csr_num     = CSR_EENTRY;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = bus.csr_rvalue;
      end
      ST_ER_RD_PRMD: bus.csr_num = CSR_PRMD;
      ST_ER_WR_CRMD: begin
        bus.csr_num    = CSR_CRMD;
        bus.csr_we     = 1'b1;
        bus.csr_wmask  = PLV_IE_MASK;
        bus.csr_wvalue = {29'b0, plv_ie_q};
      end
      ST_ER_RD_ERA: begin
        bus.csr_num     = CSR_ERA;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = bus.csr_rvalue;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // Commit pulses are only legal while idle; the FSM ignores them otherwise
  a_no_commit_while_busy: assert property (@(posedge clk) disable iff (!resetn)
    (state_q != ST_IDLE) |-> !(bus.ex_req || bus.ertn_req));
`endif

endmodule
